// File: rtl/pic_irq_ctrl_n.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pic_irq_ctrl_n : synchronous 8259-style interrupt controller  | rev 1.0
// ---------------------------------------------------------------------------
module pic_irq_ctrl_n #(
  parameter int NUM_IRQ = 8,
  parameter int IDX_W   = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [2:0]         addr,
  input  logic [NUM_IRQ-1:0] wr_data,
  output logic [NUM_IRQ-1:0] rd_data,
  input  logic               inta,
  output logic               int_out,
  output logic [7:0]         vector_out,
  output logic               vector_valid
);

  typedef enum logic [0:0] {IDLE = 1'b0, ACK1 = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [NUM_IRQ-1:0] irq_prev_q, irr_q, irr_d, isr_q, isr_d;
  logic [NUM_IRQ-1:0] imr_q, imr_d, trig_q, trig_d, rd_data_q, rd_data_d;
  logic [1:0]         ctrl_q, ctrl_d;
  logic [7:0]         vbase_q, vbase_d, vector_out_q, vector_out_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d, win_q, win_d;
  logic               spur_q, spur_d, int_out_q, int_out_d;
  logic               vector_valid_q, vector_valid_d;

  logic [NUM_IRQ-1:0] isr_set, isr_clr, pending;
  logic [IDX_W-1:0]   cand_idx, isr_hi_idx;
  logic               cand_valid;
  int                 base, cand_rank, isr_rank;

  // Rank 0 is the highest-priority position, counting up from base with wrap.
  function automatic int first_rank(input logic [NUM_IRQ-1:0] v, input int b);
    logic [NUM_IRQ-1:0] rot;
    int                 r;
    rot = NUM_IRQ'({v, v} >> b);
    r   = NUM_IRQ;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (rot[k]) r = k;
    end
    return r;
  endfunction

  always_comb begin
    state_d        = state_q;
    irr_d          = irr_q;
    imr_d          = imr_q;
    trig_d         = trig_q;
    ctrl_d         = ctrl_q;
    vbase_d        = vbase_q;
    ptr_d          = ptr_q;
    win_d          = win_q;
    spur_d         = spur_q;
    vector_out_d   = vector_out_q;
    vector_valid_d = 1'b0;
    rd_data_d      = rd_data_q;
    isr_set        = '0;
    isr_clr        = '0;

    base       = ctrl_q[1] ? ((int'(ptr_q) + 1) % NUM_IRQ) : 0;
    pending    = irr_q & ~imr_q;
    cand_rank  = first_rank(pending, base);
    isr_rank   = first_rank(isr_q, base);
    cand_valid = (cand_rank < NUM_IRQ);
    cand_idx   = IDX_W'((base + cand_rank) % NUM_IRQ);
    isr_hi_idx = IDX_W'((base + isr_rank) % NUM_IRQ);

    // Edge bits latch until acknowledged; level bits follow the registered line.
    irr_d = irr_q & trig_q;

    case (state_q)
      IDLE: begin
        if (inta) begin
          state_d = ACK1;
          if (cand_valid) begin
            win_d             = cand_idx;
            spur_d            = 1'b0;
            isr_set[cand_idx] = 1'b1;
            irr_d[cand_idx]   = 1'b0;
          end else begin
            win_d  = IDX_W'(NUM_IRQ - 1);
            spur_d = 1'b1;
          end
        end
      end
      ACK1: begin
        if (inta) begin
          state_d        = IDLE;
          vector_valid_d = 1'b1;
          vector_out_d   = vbase_q + 8'(win_q);
          if (ctrl_q[0] && !spur_q) begin
            isr_clr[win_q] = 1'b1;
            if (ctrl_q[1]) ptr_d = win_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    irr_d = irr_d | ((irq_in & ~irq_prev_q) & trig_q) | (irq_in & ~trig_q);

    if (wr_en) begin
      case (addr)
        3'd0: ctrl_d  = wr_data[1:0];
        3'd1: imr_d   = wr_data;
        3'd2: trig_d  = wr_data;
        3'd3: begin
          if (wr_data[7]) begin
            if (isr_rank < NUM_IRQ) begin
              isr_clr[isr_hi_idx] = 1'b1;
              if (ctrl_q[1]) ptr_d = isr_hi_idx;
            end
          end else if (wr_data[6]) begin
            if (int'(wr_data[IDX_W-1:0]) < NUM_IRQ) begin
              isr_clr[wr_data[IDX_W-1:0]] = 1'b1;
              if (ctrl_q[1]) ptr_d = wr_data[IDX_W-1:0];
            end
          end
        end
        3'd4: vbase_d = wr_data[7:0];
        default: ;
      endcase
    end

    isr_d = (isr_q & ~isr_clr) | isr_set;

    int_out_d = (state_q == IDLE) && !inta && cand_valid && (cand_rank < isr_rank);

    if (rd_en) begin
      case (addr)
        3'd0:    rd_data_d = NUM_IRQ'(ctrl_q);
        3'd1:    rd_data_d = imr_q;
        3'd2:    rd_data_d = trig_q;
        3'd3:    rd_data_d = irr_q;
        3'd4:    rd_data_d = NUM_IRQ'(vbase_q);
        3'd5:    rd_data_d = isr_q;
        default: rd_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      irq_prev_q     <= '0;
      irr_q          <= '0;
      isr_q          <= '0;
      imr_q          <= '1;
      trig_q         <= '0;
      ctrl_q         <= '0;
      vbase_q        <= '0;
      ptr_q          <= IDX_W'(NUM_IRQ - 1);
      win_q          <= '0;
      spur_q         <= 1'b0;
      int_out_q      <= 1'b0;
      vector_out_q   <= '0;
      vector_valid_q <= 1'b0;
      rd_data_q      <= '0;
    end else begin
      state_q        <= state_d;
      irq_prev_q     <= irq_in;
      irr_q          <= irr_d;
      isr_q          <= isr_d;
      imr_q          <= imr_d;
      trig_q         <= trig_d;
      ctrl_q         <= ctrl_d;
      vbase_q        <= vbase_d;
      ptr_q          <= ptr_d;
      win_q          <= win_d;
      spur_q         <= spur_d;
      int_out_q      <= int_out_d;
      vector_out_q   <= vector_out_d;
      vector_valid_q <= vector_valid_d;
      rd_data_q      <= rd_data_d;
    end
  end

  assign rd_data      = rd_data_q;
  assign int_out      = int_out_q;
  assign vector_out   = vector_out_q;
  assign vector_valid = vector_valid_q;

endmodule
`default_nettype wire

// File: doc/pic_irq_ctrl_n.md
Name: pic_irq_ctrl_n

Overview:
Parametrised, synchronous successor to the 8259-style interrupt controller. It provides NUM_IRQ request lines with per-channel edge/level trigger selection, fixed or rotating priority, fully nested in-service tracking, specific/non-specific/automatic EOI, and a two-pulse INTA handshake that returns an 8-bit vector. It sits between peripheral IRQ sources and the CPU interrupt input, programmed through a simple register port.

Parameters:
NUM_IRQ, 8, number of request channels; legal range 8..32.
IDX_W, 3, channel index width; must equal clog2(NUM_IRQ).

Ports:
clk  input  1  system clock; all logic is on the rising edge.
reset  input  1  synchronous, active-high reset.
irq_in  input  NUM_IRQ  raw request lines, synchronous to clk.
wr_en  input  1  register write strobe, one cycle.
rd_en  input  1  register read strobe.
addr  input  3  register address.
wr_data  input  NUM_IRQ  write data.
rd_data  output  NUM_IRQ  read data, registered, valid the cycle after rd_en.
inta  input  1  interrupt-acknowledge pulse from CPU, one cycle per pulse.
int_out  output  1  interrupt request to CPU, registered.
vector_out  output  8  acknowledged vector.
vector_valid  output  1  one-cycle strobe qualifying vector_out.

Behaviour:
- Registers. Writes: 0 CTRL ([0] AEOI, [1] ROTATE, other bits ignored); 1 IMR (1 = masked); 2 TRIG (1 = edge, 0 = level); 3 CMD ([7] non-specific EOI, [6] specific EOI on index wr_data[IDX_W-1:0], with [7] taking precedence if both are set); 4 VBASE[7:0]. Reads: 0 CTRL, 1 IMR, 2 TRIG, 3 IRR, 4 VBASE, 5 ISR. Unmapped reads return 0; unmapped writes are ignored.
- Reset values:
  - IMR all ones; CTRL, TRIG, IRR, ISR and VBASE all zero.
  - Rotation pointer (lowest-priority index) = NUM_IRQ-1.
  - int_out = 0, vector_valid = 0, vector_out = 0, rd_data = 0, state IDLE.
  - Reset mid-handshake returns to IDLE with no vector issued.
- IRR:
  - Edge channels: the bit sets on a 0->1 transition of irq_in versus its registered previous value. It clears only when that channel is acknowledged.
  - Level channels: the bit equals the registered irq_in every cycle.
- Priority:
  - ROTATE = 0: index 0 is highest.
  - ROTATE = 1: the channel at (pointer+1) mod NUM_IRQ is highest, wrapping.
  - Candidate = highest-priority set bit of IRR & ~IMR.
- int_out is asserted the cycle after the candidate exists and outranks the highest-priority ISR bit (strictly higher, fully nested). It is deasserted the cycle after the first inta pulse. A masked or lower-priority request never asserts int_out.
- State machine IDLE -> ACK1 -> IDLE:
  - IDLE, inta = 1: latch the winner index W using pre-edge state. Set ISR[W]; clear IRR[W] if W is edge-triggered; go to ACK1.
  - IDLE, inta = 1 with no candidate (spurious): W = NUM_IRQ-1; ISR is not modified; go to ACK1.
  - ACK1, inta = 1: the next cycle gives vector_out = (VBASE + W) mod 256 and vector_valid = 1 for one cycle. If AEOI = 1 and the sequence was not spurious, clear ISR[W]; with ROTATE = 1, pointer := W. Go to IDLE.
  - ACK1 waits indefinitely for the second pulse; int_out stays 0 during ACK1.
- EOI:
  - Non-specific EOI clears the highest-priority set ISR bit; with ROTATE = 1, pointer := that index. No effect if ISR = 0.
  - Specific EOI clears ISR[idx]; with ROTATE = 1, pointer := idx. An index >= NUM_IRQ is ignored.
- Simultaneous events:
  - A register write in the same cycle as inta takes effect after the winner is latched.
  - An EOI in the same cycle as an ISR set applies both; the set wins if they target the same bit.

Test Plan:
- Reset, then read IMR -> all ones; int_out = 0; vector_valid never pulses.
- VBASE = 0x40, IMR = 0, TRIG = all ones; pulse irq_in[3]; two inta pulses -> vector_out = 0x43 with one-cycle vector_valid, ISR = 0x08, IRR[3] = 0.
- ISR[2] set; raise irq_in[5] -> int_out stays 0. Raise irq_in[1] -> int_out = 1; acknowledge -> vector = VBASE+1, ISR = 0x06.
- ROTATE = 1; acknowledge and EOI channel 0 -> pointer = 0. Raise IRQ 0 and IRQ 1 together -> IRQ 1 wins first.
- AEOI = 1, level channel 4 held high -> after vector, ISR = 0 and int_out re-asserts. Drop the line -> int_out falls.
- Spurious: inta with no request -> vector = VBASE+NUM_IRQ-1, ISR unchanged. Assert reset during ACK1 -> next inta starts a fresh sequence.
